pw_arbiter: RTL and testbench

Shares the single page-table walker between NUM_RQ translation requesters: ITLB miss path and the load/store DTLBs. Requesters present a request that stays registered until accepted. The arbiter grants one request at a time using round-robin priority and drives the walker request. It broadcasts busy/rqID so each requester can hold or stall, and forwards the walker result tagged with the owning rqID.

---
 rtl/pw_arbiter_pkg.sv | 17 +
 rtl/pw_arbiter_rr_pick.sv | 28 ++
 rtl/pw_arbiter.sv | 104 ++++++++++
 tb/tb_pw_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_arbiter_pkg.sv
// Shared definitions for the page-walker arbiter and its requesters.
package pw_arbiter_pkg;

   localparam int NUM_PW_RQ = 3;

   // Fixed requester IDs; the ID is also the requester's port index.
   localparam int RQ_IFETCH = 0;
   localparam int RQ_LOAD   = 1;
   localparam int RQ_STORE  = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } PWArbState;

endpackage

// File: rtl/pw_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick #(
   parameter int N   = 3,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] idx,
   output logic           found
);

   // Rotating the doubled vector puts ptr at bit 0, so the first hit is the winner.
   logic [2*N-1:0] rot;
   assign rot = {req, req} >> ptr;

   // Scan the rotated vector and map the offset back to an absolute index.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            idx   = IDW'((int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k);
         end
      end
   end

endmodule

// File: rtl/pw_arbiter.sv
// Round-robin arbiter sharing one page-table walker between the TLB requesters.
module pw_arbiter
   import pw_arbiter_pkg::*;
#(
   parameter int NUM_RQ = NUM_PW_RQ,
   parameter int ADDR_W = 32,
   parameter int PPN_W  = 22,
   parameter int ID_W   = $clog2(NUM_RQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_RQ-1:0]              IN_rqValid,
   input  logic [NUM_RQ-1:0][ADDR_W-1:0]  IN_rqAddr,
   input  logic [NUM_RQ-1:0][PPN_W-1:0]   IN_rqRootPPN,
   input  logic                           IN_flush,
   output logic                           OUT_busy,
   output logic [ID_W-1:0]                OUT_busyID,
   output logic [NUM_RQ-1:0]              OUT_grant,
   output logic                           OUT_walkValid,
   output logic [ADDR_W-1:0]              OUT_walkAddr,
   output logic [PPN_W-1:0]               OUT_walkRootPPN,
   input  logic                           IN_walkReady,
   input  logic                           IN_walkDone,
   output logic                           OUT_resValid,
   output logic [ID_W-1:0]                OUT_resID
);

   PWArbState         state;
   logic              dropResult;
   logic [ID_W-1:0]   rrPtr;
   logic [NUM_RQ-1:0] rqMasked;
   logic [ID_W-1:0]   pickID;
   logic              pickFound;

   // The owner of an in-flight walk is never eligible, even if it misbehaves.
   always_comb begin
      rqMasked = IN_rqValid;
      if (OUT_busy) rqMasked[OUT_busyID] = 1'b0;
   end

   rr_pick #(.N(NUM_RQ), .IDW(ID_W)) uPick (
      .req   (rqMasked),
      .ptr   (rrPtr),
      .idx   (pickID),
      .found (pickFound)
   );

   // Arbitration FSM: grant, hold the walker request until accepted, wait for the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         dropResult      <= 1'b0;
         rrPtr           <= ID_W'(RQ_IFETCH);
         OUT_busy        <= 1'b0;
         OUT_busyID      <= '0;
         OUT_grant       <= '0;
         OUT_walkValid   <= 1'b0;
         OUT_walkAddr    <= '0;
         OUT_walkRootPPN <= '0;
         OUT_resValid    <= 1'b0;
         OUT_resID       <= '0;
      end else begin
         OUT_grant    <= '0;
         OUT_resValid <= 1'b0;
         case (state)
            IDLE: begin
               if (pickFound) begin
                  OUT_grant[pickID] <= 1'b1;
                  OUT_walkValid     <= 1'b1;
                  OUT_walkAddr      <= IN_rqAddr[pickID];
                  OUT_walkRootPPN   <= IN_rqRootPPN[pickID];
                  OUT_busy          <= 1'b1;
                  OUT_busyID        <= pickID;
                  dropResult        <= 1'b0;
                  rrPtr             <= (pickID == ID_W'(NUM_RQ - 1)) ? '0 : pickID + 1'b1;
                  state             <= ISSUE;
               end
            end
            ISSUE: begin
               if (IN_flush) dropResult <= 1'b1;
               if (IN_walkReady) begin
                  OUT_walkValid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (IN_flush) dropResult <= 1'b1;
               if (IN_walkDone) begin
                  // A flush seen at any point of the walk, including now, kills delivery.
                  OUT_resValid <= !(dropResult || IN_flush);
                  OUT_resID    <= OUT_busyID;
                  OUT_busy     <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A done pulse is only meaningful while waiting on the walker.
   assert property (@(posedge clk) disable iff (rst) IN_walkDone |-> state == WAIT);

endmodule

// File: tb/tb_pw_arbiter.sv
// Self-checking bench for pw_arbiter: vector table, directed corner sequences, random vs. model.
module tb_pw_arbiter;

   localparam int N = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    rqValid;
   logic [N-1:0][31:0] rqAddr;
   logic [N-1:0][21:0] rqRootPPN;
   logic            flush, walkReady, walkDone;
   logic            busy, walkValid, resValid;
   logic [1:0]      busyID, resID;
   logic [N-1:0]    grant;
   logic [31:0]     walkAddr;
   logic [21:0]     walkRootPPN;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pw_arbiter dut (
      .clk(clk), .rst(rst),
      .IN_rqValid(rqValid), .IN_rqAddr(rqAddr), .IN_rqRootPPN(rqRootPPN),
      .IN_flush(flush),
      .OUT_busy(busy), .OUT_busyID(busyID), .OUT_grant(grant),
      .OUT_walkValid(walkValid), .OUT_walkAddr(walkAddr), .OUT_walkRootPPN(walkRootPPN),
      .IN_walkReady(walkReady), .IN_walkDone(walkDone),
      .OUT_resValid(resValid), .OUT_resID(resID)
   );

   typedef struct packed {
      logic        rst;
      logic [2:0]  v;
      logic        rdy, done, fl;
      logic [2:0]  grant;
      logic        wv, busy;
      logic [1:0]  bid;
      logic        rv;
      logic [1:0]  rid;
      logic [31:0] addr;
   } vec_t;

   function automatic vec_t mkv(input int r, input int v, input int rd, input int dn, input int fl,
                                input int g, input int wv, input int b, input int bid,
                                input int rv, input int rid, input logic [31:0] a);
      vec_t t;
      t.rst = 1'(r); t.v = 3'(v); t.rdy = 1'(rd); t.done = 1'(dn); t.fl = 1'(fl);
      t.grant = 3'(g); t.wv = 1'(wv); t.busy = 1'(b); t.bid = 2'(bid);
      t.rv = 1'(rv); t.rid = 2'(rid); t.addr = a;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance past the edge, leave outputs ready to sample.
   task automatic cyc(input logic [2:0] v, input logic rd, input logic dn, input logic fl);
      rqValid = v; walkReady = rd; walkDone = dn; flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic expOut(input string nm, input logic [2:0] g, input logic wv, input logic b, input logic rv);
      chk({nm, "_grant"}, 64'(grant), 64'(g));
      chk({nm, "_walkValid"}, 64'(walkValid), 64'(wv));
      chk({nm, "_busy"}, 64'(busy), 64'(b));
      chk({nm, "_resValid"}, 64'(resValid), 64'(rv));
   endtask

   task automatic doReset();
      rst = 1'b1;
      cyc(3'b000, 1'b0, 1'b0, 1'b0);
      expOut("reset", 3'b000, 1'b0, 1'b0, 1'b0);
      chk("reset_busyID", 64'(busyID), 64'd0);
      rst = 1'b0;
   endtask

   // Reference model state (transaction view: is a walk owned, has the walker taken it).
   int   mPtr, mOwner;
   bit   mBusy, mIssued, mDrop;
   logic [2:0] pend;

   vec_t tbl[17];

   initial begin
      rst = 1'b1; rqValid = '0; flush = 1'b0; walkReady = 1'b0; walkDone = 1'b0;
      rqAddr[0] = 32'h8000_1000; rqAddr[1] = 32'h1111_2000; rqAddr[2] = 32'h2222_3000;
      rqRootPPN[0] = 22'h0_1234; rqRootPPN[1] = 22'h2_5678; rqRootPPN[2] = 22'h3_9abc;

      // ---- Vector table: single request, flush coincident with done, flush in idle ----
      //             rst  v    rdy dn fl  grant  wv b bid rv rid  addr
      tbl[0]  = mkv(1, 'b000, 0, 0, 0, 'b000, 0, 0, 0, 0, 0, 32'h0);
      tbl[1]  = mkv(0, 'b001, 0, 0, 0, 'b001, 1, 1, 0, 0, 0, 32'h8000_1000);
      tbl[2]  = mkv(0, 'b000, 1, 0, 0, 'b000, 0, 1, 0, 0, 0, 32'h0);
      tbl[3]  = mkv(0, 'b000, 0, 0, 0, 'b000, 0, 1, 0, 0, 0, 32'h0);
      tbl[4]  = mkv(0, 'b000, 0, 0, 0, 'b000, 0, 1, 0, 0, 0, 32'h0);
      tbl[5]  = mkv(0, 'b000, 0, 0, 0, 'b000, 0, 1, 0, 0, 0, 32'h0);
      tbl[6]  = mkv(0, 'b000, 0, 0, 0, 'b000, 0, 1, 0, 0, 0, 32'h0);
      tbl[7]  = mkv(0, 'b000, 0, 1, 0, 'b000, 0, 0, 0, 1, 0, 32'h0);
      tbl[8]  = mkv(0, 'b000, 0, 0, 0, 'b000, 0, 0, 0, 0, 0, 32'h0);
      tbl[9]  = mkv(0, 'b100, 0, 0, 0, 'b100, 1, 1, 2, 0, 0, 32'h2222_3000);
      tbl[10] = mkv(0, 'b000, 1, 0, 0, 'b000, 0, 1, 2, 0, 0, 32'h0);
      tbl[11] = mkv(0, 'b000, 0, 1, 1, 'b000, 0, 0, 0, 0, 0, 32'h0);
      tbl[12] = mkv(0, 'b010, 0, 0, 0, 'b010, 1, 1, 1, 0, 0, 32'h1111_2000);
      tbl[13] = mkv(0, 'b000, 1, 0, 0, 'b000, 0, 1, 1, 0, 0, 32'h0);
      tbl[14] = mkv(0, 'b000, 0, 1, 0, 'b000, 0, 0, 0, 1, 1, 32'h0);
      tbl[15] = mkv(0, 'b000, 0, 0, 1, 'b000, 0, 0, 0, 0, 0, 32'h0);
      tbl[16] = mkv(0, 'b001, 0, 0, 0, 'b001, 1, 1, 0, 0, 0, 32'h8000_1000);
      for (int i = 0; i < 17; i++) begin
         rst = tbl[i].rst;
         cyc(tbl[i].v, tbl[i].rdy, tbl[i].done, tbl[i].fl);
         expOut($sformatf("vec%0d", i), tbl[i].grant, tbl[i].wv, tbl[i].busy, tbl[i].rv);
         if (tbl[i].busy) chk($sformatf("vec%0d_busyID", i), 64'(busyID), 64'(tbl[i].bid));
         if (tbl[i].rv)   chk($sformatf("vec%0d_resID", i), 64'(resID), 64'(tbl[i].rid));
         if (tbl[i].wv)   chk($sformatf("vec%0d_addr", i), 64'(walkAddr), 64'(tbl[i].addr));
      end

      // ---- Contention: all three requesting, order 0,1,2,0 with one walk at a time ----
      doReset();
      for (int w = 0; w < 4; w++) begin
         automatic int e = w % N;
         automatic logic [2:0] others = 3'b111 & ~(3'b001 << e);
         cyc(3'b111, 1'b0, 1'b0, 1'b0);
         chk("cont_grant", 64'(grant), 64'(3'b001 << e));
         chk("cont_busyID", 64'(busyID), 64'(e));
         cyc(others, 1'b1, 1'b0, 1'b0);
         expOut("cont_inflight", 3'b000, 1'b0, 1'b1, 1'b0);
         cyc(others, 1'b0, 1'b1, 1'b0);
         expOut("cont_done", 3'b000, 1'b0, 1'b0, 1'b1);
         chk("cont_resID", 64'(resID), 64'(e));
      end

      // ---- Backpressure: request held stable while the walker stalls ----
      doReset();
      cyc(3'b010, 1'b0, 1'b0, 1'b0);
      chk("bp_grant", 64'(grant), 64'(3'b010));
      rqAddr[1] = 32'hdead_beef; rqRootPPN[1] = 22'h1_1111;
      for (int k = 0; k < 4; k++) begin
         cyc(3'b101, 1'b0, 1'b0, 1'b0);
         expOut("bp_hold", 3'b000, 1'b1, 1'b1, 1'b0);
         chk("bp_addr", 64'(walkAddr), 64'h1111_2000);
         chk("bp_ppn", 64'(walkRootPPN), 64'h2_5678);
      end
      rqAddr[1] = 32'h1111_2000; rqRootPPN[1] = 22'h2_5678;
      cyc(3'b101, 1'b1, 1'b0, 1'b0);
      expOut("bp_accept", 3'b000, 1'b0, 1'b1, 1'b0);
      cyc(3'b101, 1'b0, 1'b1, 1'b0);
      expOut("bp_done", 3'b000, 1'b0, 1'b0, 1'b1);
      chk("bp_resID", 64'(resID), 64'd1);
      cyc(3'b101, 1'b0, 1'b0, 1'b0);
      chk("bp_next_grant", 64'(grant), 64'(3'b100));

      // ---- Flush during WAIT, two cycles before done ----
      doReset();
      cyc(3'b010, 1'b0, 1'b0, 1'b0);
      chk("fw_grant", 64'(grant), 64'(3'b010));
      cyc(3'b000, 1'b1, 1'b0, 1'b0);
      cyc(3'b000, 1'b0, 1'b0, 1'b1);
      expOut("fw_flush", 3'b000, 1'b0, 1'b1, 1'b0);
      cyc(3'b000, 1'b0, 1'b0, 1'b0);
      expOut("fw_wait", 3'b000, 1'b0, 1'b1, 1'b0);
      cyc(3'b000, 1'b0, 1'b1, 1'b0);
      expOut("fw_done", 3'b000, 1'b0, 1'b0, 1'b0);
      cyc(3'b000, 1'b0, 1'b0, 1'b0);
      expOut("fw_after", 3'b000, 1'b0, 1'b0, 1'b0);
      cyc(3'b001, 1'b0, 1'b0, 1'b0);
      chk("fw_next_grant", 64'(grant), 64'(3'b001));
      cyc(3'b000, 1'b1, 1'b0, 1'b0);
      cyc(3'b000, 1'b0, 1'b1, 1'b0);
      expOut("fw_next_done", 3'b000, 1'b0, 1'b0, 1'b1);
      chk("fw_next_resID", 64'(resID), 64'd0);

      // ---- Reset mid-ISSUE, then round-robin restarts from requester 0 ----
      doReset();
      cyc(3'b100, 1'b0, 1'b0, 1'b0);
      chk("rs_grant", 64'(grant), 64'(3'b100));
      rst = 1'b1;
      cyc(3'b000, 1'b0, 1'b0, 1'b0);
      expOut("rs_cleared", 3'b000, 1'b0, 1'b0, 1'b0);
      chk("rs_busyID", 64'(busyID), 64'd0);
      rst = 1'b0;
      cyc(3'b110, 1'b0, 1'b0, 1'b0);
      chk("rs_first_grant", 64'(grant), 64'(3'b010));
      // Pointer left at 2 before reset must not survive it.
      doReset();
      cyc(3'b010, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(3'b000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(3'b110, 1'b0, 1'b0, 1'b0);
      chk("rs_ptr_grant", 64'(grant), 64'(3'b010));

      // ---- Random traffic against the transaction model ----
      doReset();
      mPtr = 0; mOwner = 0; mBusy = 0; mIssued = 0; mDrop = 0; pend = '0;
      for (int c = 0; c < 4000; c++) begin
         automatic logic [2:0] eGrant = '0;
         automatic bit eRes = 0;
         automatic int eRid = 0;
         automatic logic [31:0] eAddr = '0;
         automatic logic [21:0] ePPN = '0;
         automatic bit rd, dn, fl;
         // requesters: raise with fresh payload, occasionally give up early
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               if ($urandom_range(0, 31) == 0) pend[i] = 1'b0;
            end else if (!(mBusy && mOwner == i) && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               rqAddr[i] = $urandom;
               rqRootPPN[i] = 22'($urandom);
            end
         end
         rd = mBusy && !mIssued && ($urandom_range(0, 2) == 0);
         dn = mBusy && mIssued && ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 15) == 0);
         cyc(pend, rd, dn, fl);
         // model: who gets the walker, and what the walk delivers
         if (!mBusy) begin
            if (rqValid != 0) begin
               automatic int best = -1, bestDist = N;
               for (int i = 0; i < N; i++)
                  if (rqValid[i] && ((i - mPtr + N) % N) < bestDist) begin
                     best = i; bestDist = (i - mPtr + N) % N;
                  end
               eGrant[best] = 1'b1;
               mBusy = 1; mIssued = 0; mDrop = 0; mOwner = best;
               mPtr = (best + 1) % N;
               eAddr = rqAddr[best]; ePPN = rqRootPPN[best];
            end
         end else if (!mIssued) begin
            if (fl) mDrop = 1;
            if (rd) mIssued = 1;
         end else begin
            if (fl) mDrop = 1;
            if (dn) begin
               eRes = !mDrop; eRid = mOwner; mBusy = 0;
            end
         end
         chk("rnd_grant", 64'(grant), 64'(eGrant));
         chk("rnd_walkValid", 64'(walkValid), 64'(mBusy && !mIssued));
         chk("rnd_busy", 64'(busy), 64'(mBusy));
         chk("rnd_resValid", 64'(resValid), 64'(eRes));
         if (mBusy) chk("rnd_busyID", 64'(busyID), 64'(mOwner));
         if (eRes) chk("rnd_resID", 64'(resID), 64'(eRid));
         if (eGrant != 0) begin
            chk("rnd_addr", 64'(walkAddr), 64'(eAddr));
            chk("rnd_ppn", 64'(walkRootPPN), 64'(ePPN));
         end
         for (int i = 0; i < N; i++) if (grant[i]) pend[i] = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
